// File: rtl/rr_grant_ctrl_8.sv
// rtl/rr_grant_ctrl_8.sv - 8-way round-robin arbiter with active-low one-hot grant
//
// Purpose: shares one resource among 8 requesters. A requester owns the
// resource until it pulses done or drops its request; disabling the arbiter
// (en != 3'b001) preempts the current owner without moving priority. Every
// release is followed by at least one idle cycle before the next arbitration.
//
// Optional feature: define HOLD_LIMIT_EN to bound each grant to MAX_HOLD
// cycles; the forced release pulses hold_expired.
//
// Ports:
//   clk          rising-edge system clock
//   rst          synchronous active-high reset
//   en[2:0]      arbitration enable, active only when 3'b001
//   req[7:0]     active-high requests, one bit per requester
//   done         one-cycle release pulse from the current grantee
//   gnt_n[7:0]   active-low one-hot grant, 8'hFF when nobody owns the resource
//   gnt_idx[2:0] binary index of the grantee, 0 when idle
//   gnt_valid    high while a grant is held
//   hold_expired one-cycle pulse on a forced (hold limit) release

module rr_grant_ctrl_8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] en,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt_n,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       hold_expired
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0] state;
  logic [2:0] ptr;
  logic       arb_en;
  logic       win_found;
  logic [2:0] win_idx;
  logic [2:0] cand;
  logic       hold_hit;

  assign arb_en = (en == 3'b001);

  // Search ptr, ptr+1, ... wrapping mod 8. The loop runs from the farthest
  // offset down so the nearest set request is the last (winning) assignment.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr;
    cand      = ptr;
    for (int i = 7; i >= 0; i--) begin
      cand = ptr + 3'(i);
      if (req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

`ifdef HOLD_LIMIT_EN
  logic [7:0] hold_cnt;

  // Counter sits at 0 throughout IDLE, so it is 0 on the first GRANT cycle
  // and equals the number of completed GRANT cycles after that.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= 8'd0;
    end else if (state == S_IDLE) begin
      hold_cnt <= 8'd0;
    end else begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end

  // True at the edge that would complete MAX_HOLD cycles in GRANT.
  assign hold_hit = (({1'b0, hold_cnt} + 9'd1) >= 9'(MAX_HOLD));
`else
  logic [7:0] unused_max_hold;
  assign unused_max_hold = 8'(MAX_HOLD);
  assign hold_hit        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      ptr          <= 3'd0;
      gnt_n        <= 8'hFF;
      gnt_idx      <= 3'd0;
      gnt_valid    <= 1'b0;
      hold_expired <= 1'b0;
    end else begin
      hold_expired <= 1'b0;
      case (state)
        S_IDLE: begin
          if (arb_en && win_found) begin
            state     <= S_GRANT;
            gnt_idx   <= win_idx;
            gnt_n     <= ~(8'b0000_0001 << win_idx);
            gnt_valid <= 1'b1;
          end
        end
        S_GRANT: begin
          // Release priority: preemption, then done/req-drop, then hold limit.
          if (!arb_en) begin
            // Preempted owner keeps top priority: ptr untouched.
            state     <= S_IDLE;
            gnt_n     <= 8'hFF;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
          end else if (done || !req[gnt_idx]) begin
            state     <= S_IDLE;
            ptr       <= gnt_idx + 3'd1;
            gnt_n     <= 8'hFF;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
          end else if (hold_hit) begin
            state        <= S_IDLE;
            ptr          <= gnt_idx + 3'd1;
            gnt_n        <= 8'hFF;
            gnt_idx      <= 3'd0;
            gnt_valid    <= 1'b0;
            hold_expired <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          gnt_n     <= 8'hFF;
          gnt_idx   <= 3'd0;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_grant_ctrl_8.sv
// tb/tb_rr_grant_ctrl_8.sv - scoreboard bench for rr_grant_ctrl_8

module tb_rr_grant_ctrl_8;

  localparam logic [2:0] EN_ON = 3'b001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] en = 3'b000;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [7:0] gnt_n;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       hold_expired;

  typedef struct {
    string      name;
    logic [7:0] gn;
    logic [2:0] idx;
    logic       v;
    logic       hx;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  rr_grant_ctrl_8 #(.MAX_HOLD(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .req          (req),
    .done         (done),
    .gnt_n        (gnt_n),
    .gnt_idx      (gnt_idx),
    .gnt_valid    (gnt_valid),
    .hold_expired (hold_expired)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected after the next
  // rising edge. exp_owner < 0 means no grant.
  task automatic vec(input string nm, input logic r, input logic [2:0] e,
                     input logic [7:0] q, input logic d, input int exp_owner,
                     input logic exp_hx);
    exp_t x;
    logic [7:0] one;
    @(negedge clk);
    rst  = r;
    en   = e;
    req  = q;
    done = d;
    one  = 8'h01;
    x.name = nm;
    x.hx   = exp_hx;
    if (exp_owner >= 0) begin
      x.v   = 1'b1;
      x.idx = 3'(exp_owner);
      x.gn  = ~(one << exp_owner);
    end else begin
      x.v   = 1'b0;
      x.idx = 3'd0;
      x.gn  = 8'hFF;
    end
    sb.push_back(x);
  endtask

  // Monitor: outputs are registered, so one result appears after every edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        n_vec++;
        if (gnt_n !== x.gn || gnt_idx !== x.idx || gnt_valid !== x.v ||
            hold_expired !== x.hx) begin
          n_miss++;
          $display("FAIL %s: got gnt_n=%b idx=%0d valid=%b hx=%b, expected gnt_n=%b idx=%0d valid=%b hx=%b",
                   x.name, gnt_n, gnt_idx, gnt_valid, hold_expired,
                   x.gn, x.idx, x.v, x.hx);
        end
      end
    end
  end

  initial begin
    int budget;
    vec("reset_a", 1, 3'b000, 8'h00, 0, -1, 0);
    vec("reset_b", 1, 3'b000, 8'h00, 0, -1, 0);

    vec("single_grant", 0, EN_ON, 8'h04, 0, 2, 0);
    vec("done_release", 0, EN_ON, 8'h04, 1, -1, 0);
    vec("ptr3_check",   0, EN_ON, 8'h09, 0, 3, 0);
    vec("rel3",         0, EN_ON, 8'h09, 1, -1, 0);
    vec("reset_over",   1, EN_ON, 8'hFF, 0, -1, 0);

    for (int k = 0; k < 9; k++) begin
      vec("fair_grant",   0, EN_ON, 8'hFF, 0, k % 8, 0);
      vec("fair_release", 0, EN_ON, 8'hFF, 1, -1, 0);
    end

    vec("pre_g5",             0, EN_ON, 8'h20, 0, 5, 0);
    vec("req_drop",           0, EN_ON, 8'h00, 0, -1, 0);
    vec("idle_done_ignored",  0, EN_ON, 8'h00, 1, -1, 0);
    vec("wrap_win0",          0, EN_ON, 8'h09, 0, 0, 0);
    vec("rel0",               0, EN_ON, 8'h09, 1, -1, 0);
    vec("skip_win3",          0, EN_ON, 8'h09, 0, 3, 0);
    vec("other_bits_ignored", 0, EN_ON, 8'h0F, 0, 3, 0);
    vec("rel3b",              0, EN_ON, 8'h0F, 1, -1, 0);

    vec("g5",           0, EN_ON,  8'h20, 0, 5, 0);
    vec("preempt",      0, 3'b010, 8'h20, 0, -1, 0);
    vec("idle_en_off",  0, 3'b000, 8'h23, 0, -1, 0);
    vec("regrant5",     0, EN_ON,  8'h23, 0, 5, 0);
    vec("preempt_done", 0, 3'b010, 8'h23, 1, -1, 0);
    vec("regrant5b",    0, EN_ON,  8'h23, 0, 5, 0);
    vec("rel5",         0, EN_ON,  8'h23, 1, -1, 0);

    vec("g4",       0, EN_ON, 8'h10, 0, 4, 0);
    vec("hold4",    0, EN_ON, 8'h10, 0, 4, 0);
    vec("rst_mid",  1, EN_ON, 8'h10, 0, -1, 0);
    vec("rst_ptr0", 0, EN_ON, 8'h90, 0, 4, 0);
    vec("rel4",     0, EN_ON, 8'h90, 1, -1, 0);

    vec("hold_grant1", 0, EN_ON, 8'h06, 0, 1, 0);
`ifdef HOLD_LIMIT_EN
    vec("hold1_c2",   0, EN_ON, 8'h06, 0, 1, 0);
    vec("hold1_c3",   0, EN_ON, 8'h06, 0, 1, 0);
    vec("expire1",    0, EN_ON, 8'h06, 0, -1, 1);
    vec("grant2",     0, EN_ON, 8'h06, 0, 2, 0);
    vec("hold2_c2",   0, EN_ON, 8'h06, 0, 2, 0);
    vec("hold2_c3",   0, EN_ON, 8'h06, 0, 2, 0);
    vec("expire2",    0, EN_ON, 8'h06, 0, -1, 1);
    vec("grant1_again", 0, EN_ON, 8'h06, 0, 1, 0);
`else
    for (int k = 0; k < 20; k++) begin
      vec("unbounded_hold", 0, EN_ON, 8'h06, 0, 1, 0);
    end
`endif

    budget = 0;
    while (sb.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    if (sb.size() > 0) begin
      n_miss++;
      $display("FAIL drain: %0d results still pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/rr_grant_ctrl_8.md
Name: rr_grant_ctrl_8

Overview:
- Round-robin arbiter that shares one resource among 8 requesters.
- Grant is presented as an active-low one-hot bus, the same 3-to-8 decoder output convention used in the lab1 datapath. A 3-bit enable uses the same "3'b001 = active" code as the decoder.
- Sits between requester blocks (e.g. display/LED drivers) and the shared resource. Sequences who owns it and for how long.

Parameters:
- MAX_HOLD, 16, maximum cycles one grant may be held. Range 1..255. Used only when HOLD_LIMIT_EN is defined.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  3  arbitration enable. Active only when en == 3'b001; any other value is disabled.
- req  input  8  active-high request, one bit per requester.
- done  input  1  one-cycle pulse from the current grantee releasing the resource.
- gnt_n  output  8  active-low one-hot grant (bit i low = requester i owns the resource); 8'hFF = none.
- gnt_idx  output  3  binary index of current grantee; 0 when no grant.
- gnt_valid  output  1  high while a grant is held.
- hold_expired  output  1  one-cycle pulse on a forced release. Tied 0 without HOLD_LIMIT_EN.

Behaviour:
- Reset (rst=1 at an edge): state IDLE, gnt_n=8'hFF, gnt_idx=3'd0, gnt_valid=0, hold_expired=0, internal priority pointer ptr=3'd0, hold counter=0. Reset overrides every other input, including mid-grant.
- All outputs are registered. There is no combinational path from any input to any output.
- States:
  - IDLE: no grant.
  - GRANT: one requester owns the resource.
- IDLE -> GRANT: at an edge where en==3'b001 and req!=0.
  - Winner = first set req bit searching ptr, ptr+1, ... wrapping mod 8.
  - After that edge: gnt_idx=winner, gnt_n=~(8'b1<<winner), gnt_valid=1.
  - Latency: request sampled at edge k produces the grant visible after edge k.
- IDLE with en!=3'b001 or req==0: stay in IDLE, outputs unchanged at idle values.
- GRANT -> IDLE (normal release): at an edge where done==1 or req[gnt_idx]==0.
  - gnt_n=8'hFF, gnt_valid=0, gnt_idx=0.
  - ptr=(gnt_idx+1) mod 8, so 7 wraps to 0.
- GRANT -> IDLE (preemption): at an edge where en!=3'b001.
  - Outputs go to idle values.
  - ptr is NOT advanced, so the preempted requester keeps top priority.
- Priority when several release conditions hold at one edge: preemption (en) > done/req-drop > hold limit. Exactly one release occurs and ptr is updated once.
- Every release is followed by at least one IDLE cycle (one-cycle bubble). Arbitration happens only in IDLE.
- done while in IDLE is ignored.
- In GRANT, req changes on bits other than gnt_idx are ignored.
- Single requester asserting continuously: it is re-granted after each bubble.

Optional Feature:
- Macro HOLD_LIMIT_EN.
- When defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each cycle in GRANT.
  - When the counter has counted MAX_HOLD cycles with no other release, the next edge forces release to IDLE.
  - ptr advances as in a normal release.
  - hold_expired pulses high for exactly one cycle, coincident with gnt_valid falling.
- When undefined: no counter is built, grants are unbounded, and hold_expired is constant 0.

Test Plan:
- Reset, then en=3'b001, req=8'b0000_0100 → one edge later gnt_n=8'b1111_1011, gnt_idx=2, gnt_valid=1. After done pulse → gnt_n=8'hFF, gnt_valid=0, ptr=3.
- Fairness: req=8'hFF held, done pulsed after each grant → grant order 0,1,2,...,7,0, each separated by one idle cycle.
- Wrap and skip: ptr=6 with req=8'b0000_1001 → winner 0; next arbitration with same req → winner 3.
- Preemption: granted to 5, en changed to 3'b010 → next edge gnt_n=8'hFF. Restore en=3'b001 with req[5] still high → 5 re-granted before any other set bit.
- Reset mid-grant: gnt_idx=4 held, rst=1 for one edge → all outputs at reset values. Next arbitration starts from ptr=0.
- HOLD_LIMIT_EN with MAX_HOLD=3: req=8'b0000_0010 held, no done → gnt_valid high 3 cycles, then low with hold_expired=1 for one cycle, ptr=2. Without the macro, the grant stays indefinitely.
